// File: rtl/bid_arbiter_n.sv
// bid_arbiter_n: N-bidder sealed-bid round arbiter.
//
// The controller configures per-bidder balances, bid mask, bid charge and
// lockout timer while UNLOCKED, then locks with a key and runs rounds by
// holding C_start high. During a round each bidder may bid (charged a fee)
// or retract. When C_start drops, one RESULT cycle picks the highest stored
// bid, debits the winner and pulses roundOver.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   C_op/C_data      controller opcode and operand
//   C_idx            bidder index for LoadBal
//   C_start          round active level
//   bid_req/bid_amt  per-bidder bid strobe and packed amounts
//   retract          per-bidder retract strobe
//   ready            low only in the cycle after reset is applied
//   err              controller error pulse
//   ack, bidder_err  per-bidder accept pulse / 2-bit error pulse
//   balance          packed current balances
//   win, maxBid      one-hot winner and winning amount (held)
//   roundOver        one-cycle result pulse
module bid_arbiter_n #(
  parameter int          NUM_BIDDERS = 3,
  parameter int          AMT_W       = 16,
  parameter int          BAL_W       = 32,
  parameter int          TIE_MODE    = 0,
  parameter logic [31:0] RESET_KEY   = 32'h0F0F0F0F
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     C_op,
  input  logic [31:0]                    C_data,
  input  logic [$clog2(NUM_BIDDERS)-1:0] C_idx,
  input  logic                           C_start,
  input  logic [NUM_BIDDERS-1:0]         bid_req,
  input  logic [NUM_BIDDERS*AMT_W-1:0]   bid_amt,
  input  logic [NUM_BIDDERS-1:0]         retract,
  output logic                           ready,
  output logic [2:0]                     err,
  output logic [NUM_BIDDERS-1:0]         ack,
  output logic [2*NUM_BIDDERS-1:0]       bidder_err,
  output logic [NUM_BIDDERS*BAL_W-1:0]   balance,
  output logic [NUM_BIDDERS-1:0]         win,
  output logic [AMT_W-1:0]               maxBid,
  output logic                           roundOver
);

  typedef enum logic [2:0] {S_UNLOCKED, S_LOCKED, S_LOCKOUT, S_ROUND, S_RESULT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_UNLOCK, OP_LOCK, OP_LOAD_BAL, OP_SET_MASK, OP_SET_TIMER, OP_BID_CHARGE
  } op_t;
  typedef enum logic [2:0] {
    ERR_OK, ERR_KEY, ERR_UNLOCKED, ERR_START, ERR_OPCODE, ERR_TIE, ERR_LOCKED, ERR_NO_BID
  } err_t;
  typedef enum logic [1:0] {BE_OK, BE_INACTIVE, BE_FUNDS, BE_MASKED} berr_t;

  state_t                 state_q, state_d;
  logic [31:0]            key_q, key_d;
  logic [NUM_BIDDERS-1:0] mask_q, mask_d;
  logic [BAL_W-1:0]       timer_q, timer_d, cost_q, cost_d, down_q, down_d;
  logic [BAL_W-1:0]       bal_q [NUM_BIDDERS];
  logic [BAL_W-1:0]       bal_d [NUM_BIDDERS];
  logic [AMT_W-1:0]       bid_q [NUM_BIDDERS];
  logic [AMT_W-1:0]       bid_d [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0] bid_valid_q, bid_valid_d;
  err_t                   err_q, err_d;
  logic [NUM_BIDDERS-1:0] ack_q, ack_d, win_q, win_d;
  logic [2*NUM_BIDDERS-1:0] berr_q, berr_d;
  logic [AMT_W-1:0]       max_q, max_d;
  logic                   ro_q, ro_d, ready_q;

  // Winner search over the stored bids; a stored amount of 0 is a real bid.
  logic [AMT_W-1:0]       top_amt;
  logic                   any_bid, top_tie;
  logic [NUM_BIDDERS-1:0] top_vec, top_first;

  always_comb begin
    top_amt = '0;
    any_bid = 1'b0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (bid_valid_q[i] && (!any_bid || bid_q[i] > top_amt)) begin
        top_amt = bid_q[i];
        any_bid = 1'b1;
      end
    end
    top_vec = '0;
    for (int i = 0; i < NUM_BIDDERS; i++)
      top_vec[i] = bid_valid_q[i] && (bid_q[i] == top_amt);
    // Lowest set bit is the lowest tied index; more than one bit means a tie.
    top_first = top_vec & (~top_vec + NUM_BIDDERS'(1));
    top_tie   = (top_vec & (top_vec - NUM_BIDDERS'(1))) != '0;
  end

  // Error for an opcode arriving in any state that refuses configuration.
  err_t op_err_locked;
  always_comb begin
    if (C_op == OP_NOP)             op_err_locked = ERR_OK;
    else if (C_op > OP_BID_CHARGE)  op_err_locked = ERR_OPCODE;
    else                            op_err_locked = ERR_LOCKED;
  end

  logic [BAL_W:0] need;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    key_d       = key_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    cost_d      = cost_q;
    down_d      = down_q;
    bal_d       = bal_q;
    bid_d       = bid_q;
    bid_valid_d = bid_valid_q;
    win_d       = win_q;
    max_d       = max_q;
    err_d       = ERR_OK;
    ack_d       = '0;
    berr_d      = '0;
    ro_d        = 1'b0;
    need        = '0;

    unique case (state_q)
      S_UNLOCKED: begin
        case (C_op)
          OP_NOP:        ;
          OP_UNLOCK:     err_d = ERR_UNLOCKED;
          OP_LOCK: begin
            key_d       = C_data;
            bid_valid_d = '0;
            state_d     = S_LOCKED;
          end
          OP_LOAD_BAL: begin
            if (32'(C_idx) < NUM_BIDDERS) bal_d[C_idx] = BAL_W'(C_data);
            else                          err_d = ERR_OPCODE;
          end
          OP_SET_MASK:   mask_d  = C_data[NUM_BIDDERS-1:0];
          OP_SET_TIMER:  timer_d = BAL_W'(C_data);
          OP_BID_CHARGE: cost_d  = BAL_W'(C_data);
          default:       err_d = ERR_OPCODE;
        endcase
        // A stray C_start is only reported when the op itself was clean.
        if (C_start && err_d == ERR_OK) err_d = ERR_START;
      end

      S_LOCKED: begin
        if (C_op == OP_UNLOCK) begin
          if (C_data == key_q) begin
            state_d = S_UNLOCKED;
          end else begin
            err_d   = ERR_KEY;
            down_d  = (timer_q == '0) ? BAL_W'(1) : timer_q;
            state_d = S_LOCKOUT;
          end
        end else begin
          err_d = op_err_locked;
          if (C_start) begin
            state_d     = S_ROUND;
            bid_valid_d = '0;
            win_d       = '0;
            max_d       = '0;
          end
        end
      end

      S_LOCKOUT: begin
        if (C_op != OP_NOP) err_d = ERR_LOCKED;
        down_d = down_q - BAL_W'(1);
        if (down_q == BAL_W'(1)) state_d = S_LOCKED;
      end

      S_ROUND: begin
        err_d = op_err_locked;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
          need = (BAL_W+1)'(bid_amt[i*AMT_W +: AMT_W]) + (BAL_W+1)'(cost_q);
          if (retract[i]) begin
            bid_valid_d[i] = 1'b0;
          end else if (bid_req[i]) begin
            if (!mask_q[i]) begin
              berr_d[2*i +: 2] = BE_MASKED;
            end else if ({1'b0, bal_q[i]} >= need) begin
              bid_d[i]       = bid_amt[i*AMT_W +: AMT_W];
              bid_valid_d[i] = 1'b1;
              bal_d[i]       = bal_q[i] - cost_q;
              ack_d[i]       = 1'b1;
            end else begin
              berr_d[2*i +: 2] = BE_FUNDS;
              bal_d[i] = (bal_q[i] >= cost_q) ? bal_q[i] - cost_q : '0;
            end
          end
        end
        if (!C_start) state_d = S_RESULT;
      end

      S_RESULT: begin
        err_d   = op_err_locked;
        ro_d    = 1'b1;
        state_d = S_LOCKED;
        // The round outcome takes the single err slot over any op error.
        if (!any_bid) begin
          err_d = ERR_NO_BID;
        end else if (top_tie && TIE_MODE == 0) begin
          err_d = ERR_TIE;
          win_d = '0;
          max_d = '0;
        end else begin
          win_d = top_first;
          max_d = top_amt;
          for (int i = 0; i < NUM_BIDDERS; i++)
            if (top_first[i]) bal_d[i] = bal_q[i] - BAL_W'(top_amt);
        end
      end

      default: state_d = S_UNLOCKED;
    endcase

    if (state_q != S_ROUND) begin
      for (int i = 0; i < NUM_BIDDERS; i++)
        if (bid_req[i] || retract[i]) berr_d[2*i +: 2] = BE_INACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_UNLOCKED;
      key_q       <= RESET_KEY;
      mask_q      <= '1;
      timer_q     <= BAL_W'(15);
      cost_q      <= BAL_W'(1);
      down_q      <= '0;
      // NOTE: balances and stored amounts are architecturally visible after
      // reset, so this small array is reset entry by entry rather than left
      // as an unreset memory.
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        bal_q[i] <= '0;
        bid_q[i] <= '0;
      end
      bid_valid_q <= '0;
      err_q       <= ERR_OK;
      ack_q       <= '0;
      berr_q      <= '0;
      win_q       <= '0;
      max_q       <= '0;
      ro_q        <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q     <= state_d;
      key_q       <= key_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      cost_q      <= cost_d;
      down_q      <= down_d;
      bal_q       <= bal_d;
      bid_q       <= bid_d;
      bid_valid_q <= bid_valid_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      berr_q      <= berr_d;
      win_q       <= win_d;
      max_q       <= max_d;
      ro_q        <= ro_d;
      ready_q     <= 1'b1;
    end
  end

  assign ready      = ready_q;
  assign err        = err_q;
  assign ack        = ack_q;
  assign bidder_err = berr_q;
  assign win        = win_q;
  assign maxBid     = max_q;
  assign roundOver  = ro_q;

  for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_pack
    assign balance[g*BAL_W +: BAL_W] = bal_q[g];
  end

endmodule
